// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory port between instruction fetch and data access.
// Optional macro ARB_RR_EN: round-robin on contention (default is fixed priority, DM wins).
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [2:0]            dm_width,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_width,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic {StIdle, StBusy} arbStateT;

    localparam logic       OwnIf    = 1'b0;
    localparam logic       OwnDm    = 1'b1;
    localparam logic [3:0] LatCnt   = 4'(MEM_LATENCY);
    localparam logic [2:0] WordSize = 3'b010;

    arbStateT   stateQ, stateD;
    logic [3:0] cntQ, cntD;
    logic       ownerQ, ownerD;
    logic       free;
    logic       grantIf, grantDm;
    logic       acceptRead;
    logic       respCycle;

    // The final count cycle can already launch the next access.
    assign free       = (stateQ == StIdle) || (stateQ == StBusy && cntQ == 4'd1);
    assign respCycle  = (stateQ == StBusy) && (cntQ == 4'd1);
    assign acceptRead = grantIf || (grantDm && !dm_we);

`ifdef ARB_RR_EN
    logic rrPtrQ, rrPtrD;

    always_comb begin
        rrPtrD = rrPtrQ;
        if (free && !rst && if_req && dm_req) begin
            rrPtrD = grantIf ? OwnDm : OwnIf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtrQ <= OwnIf;
        end else begin
            rrPtrQ <= rrPtrD;
        end
    end
`endif

    // Grants are suppressed while reset is held so nothing is accepted during it.
    always_comb begin
        grantIf = 1'b0;
        grantDm = 1'b0;
        if (free && !rst) begin
            if (if_req && dm_req) begin
`ifdef ARB_RR_EN
                if (rrPtrQ == OwnIf) begin
                    grantIf = 1'b1;
                end else begin
                    grantDm = 1'b1;
                end
`else
                grantDm = 1'b1;
`endif
            end else begin
                grantIf = if_req;
                grantDm = dm_req;
            end
        end
    end

    assign if_gnt = grantIf;
    assign dm_gnt = grantDm;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_width = 3'b000;
        if (grantDm) begin
            mem_req   = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_width = dm_width;
        end else if (grantIf) begin
            mem_req   = 1'b1;
            mem_addr  = if_addr;
            mem_width = WordSize;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        ownerD = ownerQ;
        if (stateQ == StBusy) begin
            cntD = cntQ - 4'd1;
            if (cntQ == 4'd1) begin
                stateD = StIdle;
            end
        end
        // A read accepted on the last count cycle reloads instead of idling.
        if (acceptRead) begin
            stateD = StBusy;
            cntD   = LatCnt;
            ownerD = grantDm ? OwnDm : OwnIf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
            ownerQ <= OwnIf;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            ownerQ <= ownerD;
        end
    end

    assign if_rvalid = respCycle && (ownerQ == OwnIf);
    assign dm_rvalid = respCycle && (ownerQ == OwnDm);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign busy      = (stateQ == StBusy);

endmodule
